bean_map: RTL and testbench

BEAN_MAP -- requirements
Module: bean_map

---
 rtl/pac_pkg.sv | 18 +
 rtl/pix2cell.sv | 24 ++
 rtl/bean_map.sv | 139 +++++++++++++
 tb/tb_bean_map.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared constants and FSM encoding for the pac-man bean map.
package pac_pkg;

    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int CELL_SHIFT = 4;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int NCELLS     = COLS * ROWS;
    localparam int BEAN_COUNT = (COLS - 2) * (ROWS - 2);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CHECK = 2'd2
    } map_state_t;

endpackage

// File: rtl/pix2cell.sv
// Converts a pixel position into a flat cell index and flags off-screen positions.
module pix2cell #(
    parameter int COLS       = pac_pkg::COLS,
    parameter int CELL_SHIFT = pac_pkg::CELL_SHIFT
) (
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    output logic [10:0] idx,
    output logic        valid
);
    import pac_pkg::*;

    logic [5:0] col;
    logic [4:0] row;

    // Cell coordinates are the pixel position divided by the cell size.
    always_comb begin
        col   = 6'(x >> CELL_SHIFT);
        row   = 5'(y >> CELL_SHIFT);
        idx   = 11'(row * COLS + col);
        valid = (x < 10'(SCREEN_W)) && (y < 9'(SCREEN_H));
    end

endmodule

// File: rtl/bean_map.sv
// Bean bitmap for one level: fills the maze, services eat requests, scores.
module bean_map #(
    parameter int COLS       = pac_pkg::COLS,
    parameter int ROWS       = pac_pkg::ROWS,
    parameter int CELL_SHIFT = pac_pkg::CELL_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic                 eat_valid,
    output logic                 eat_ready,
    input  logic [9:0]           eat_x,
    input  logic [8:0]           eat_y,
    input  logic [5:0]           rd_col,
    input  logic [4:0]           rd_row,
    output logic                 rd_bean,
    output logic [COLS*ROWS-1:0] beans,
    output logic [10:0]          score,
    output logic [10:0]          remaining,
    output logic                 init_done,
    output logic                 all_eaten
);
    import pac_pkg::*;

    map_state_t  state;
    map_state_t  next_state;
    logic [10:0] init_idx;
    logic [5:0]  init_col;
    logic [4:0]  init_row;
    logic [9:0]  cap_x;
    logic [8:0]  cap_y;
    logic [10:0] cell_idx;
    logic        cell_valid;
    logic        border;
    logic        last_cell;
    logic        accept;
    logic [10:0] rd_idx;
    logic        rd_in_range;

    pix2cell #(
        .COLS       (COLS),
        .CELL_SHIFT (CELL_SHIFT)
    ) u_pix2cell (
        .x     (cap_x),
        .y     (cap_y),
        .idx   (cell_idx),
        .valid (cell_valid)
    );

    // Derived flags for the fill walk, request handshake and renderer read port.
    always_comb begin
        border      = (init_row == 5'd0) || (init_row == 5'(ROWS - 1)) ||
                      (init_col == 6'd0) || (init_col == 6'(COLS - 1));
        last_cell   = (init_idx == 11'(COLS * ROWS - 1));
        eat_ready   = (state == IDLE);
        accept      = eat_valid && eat_ready;
        init_done   = (state != INIT);
        all_eaten   = init_done && (remaining == 11'd0);
        rd_idx      = 11'(rd_row * COLS + rd_col);
        rd_in_range = (rd_col < 6'(COLS)) && (rd_row < 5'(ROWS));
    end

    // State register; a restart from any state goes back to filling the map.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; restart beats a same-edge acceptance.
    always_comb begin
        next_state = state;
        case (state)
            INIT:    if (last_cell) next_state = IDLE;
            IDLE:    if (accept) next_state = CHECK;
            CHECK:   next_state = IDLE;
            default: next_state = INIT;
        endcase
        if (restart) begin
            next_state = INIT;
        end
    end

    // Bitmap, counters, captured request and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx  <= '0;
            init_col  <= '0;
            init_row  <= '0;
            cap_x     <= '0;
            cap_y     <= '0;
            score     <= '0;
            remaining <= '0;
            rd_bean   <= 1'b0;
            beans     <= '0;
        end else begin
            rd_bean <= rd_in_range ? beans[rd_idx] : 1'b0;
            if (restart) begin
                init_idx  <= '0;
                init_col  <= '0;
                init_row  <= '0;
                remaining <= '0;
            end else begin
                case (state)
                    INIT: begin
                        beans[init_idx] <= !border;
                        init_idx        <= init_idx + 11'd1;
                        if (init_col == 6'(COLS - 1)) begin
                            init_col <= '0;
                            init_row <= init_row + 5'd1;
                        end else begin
                            init_col <= init_col + 6'd1;
                        end
                        if (last_cell) begin
                            remaining <= 11'(BEAN_COUNT);
                        end
                    end
                    IDLE: begin
                        if (accept) begin
                            cap_x <= eat_x;
                            cap_y <= eat_y;
                        end
                    end
                    CHECK: begin
                        if (cell_valid && beans[cell_idx]) begin
                            beans[cell_idx] <= 1'b0;
                            score           <= (score == 11'd2047) ? score : score + 11'd1;
                            remaining       <= remaining - 11'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bean_map.sv
// Directed bench for bean_map: fill timing, eat vectors, read port, restart/reset corners.
module tb_bean_map;

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          eat_valid;
    logic          eat_ready;
    logic [9:0]    eat_x;
    logic [8:0]    eat_y;
    logic [5:0]    rd_col;
    logic [4:0]    rd_row;
    logic          rd_bean;
    logic [1199:0] beans;
    logic [10:0]   score;
    logic [10:0]   remaining;
    logic          init_done;
    logic          all_eaten;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        int         idx;
        int         exp_bit;
        int         exp_score;
        int         exp_rem;
    } eat_vec_t;

    typedef struct {
        logic [5:0] col;
        logic [4:0] row;
        int         exp_bean;
    } rd_vec_t;

    eat_vec_t eat_tab[9];
    rd_vec_t  rd_tab[8];

    bean_map dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .eat_valid (eat_valid),
        .eat_ready (eat_ready),
        .eat_x     (eat_x),
        .eat_y     (eat_y),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
        .rd_bean   (rd_bean),
        .beans     (beans),
        .score     (score),
        .remaining (remaining),
        .init_done (init_done),
        .all_eaten (all_eaten)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One complete eat: acceptance edge, then the CHECK edge.
    task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y);
        eat_x     = x;
        eat_y     = y;
        eat_valid = 1'b1;
        step();
        eat_valid = 1'b0;
        step();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 2000) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        eat_tab[0] = '{10'd40,  9'd40,  82,   0, 1, 1063};
        eat_tab[1] = '{10'd40,  9'd40,  82,   0, 1, 1063};
        eat_tab[2] = '{10'd700, 9'd100, 82,   0, 1, 1063};
        eat_tab[3] = '{10'd100, 9'd500, 246,  1, 1, 1063};
        eat_tab[4] = '{10'd639, 9'd479, 1199, 0, 1, 1063};
        eat_tab[5] = '{10'd24,  9'd24,  41,   0, 2, 1062};
        eat_tab[6] = '{10'd623, 9'd463, 1158, 0, 3, 1061};
        eat_tab[7] = '{10'd47,  9'd40,  82,   0, 3, 1061};
        eat_tab[8] = '{10'd320, 9'd240, 620,  0, 4, 1060};

        rd_tab[0] = '{6'd2,  5'd2,  0};
        rd_tab[1] = '{6'd3,  5'd2,  1};
        rd_tab[2] = '{6'd45, 5'd2,  0};
        rd_tab[3] = '{6'd3,  5'd30, 0};
        rd_tab[4] = '{6'd39, 5'd5,  0};
        rd_tab[5] = '{6'd0,  5'd0,  0};
        rd_tab[6] = '{6'd38, 5'd28, 0};
        rd_tab[7] = '{6'd1,  5'd28, 1};

        rst       = 1'b1;
        restart   = 1'b0;
        eat_valid = 1'b0;
        eat_x     = '0;
        eat_y     = '0;
        rd_col    = '0;
        rd_row    = '0;
        step();
        step();
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_remaining", remaining, 0);
        checkOutput("rst_rd_bean", rd_bean, 0);
        checkOutput("rst_beans_zero", (beans == '0) ? 1 : 0, 1);
        checkOutput("rst_eat_ready", eat_ready, 0);

        rst = 1'b0;
        wait_init(n);
        checkOutput("init_cycles", n, 1200);
        checkOutput("init_done", init_done, 1);
        checkOutput("init_remaining", remaining, 1064);
        checkOutput("init_bean0", beans[0], 0);
        checkOutput("init_bean41", beans[41], 1);
        checkOutput("init_bean1199", beans[1199], 0);
        checkOutput("init_score", score, 0);
        checkOutput("init_all_eaten", all_eaten, 0);

        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("vec%0d_ready_before", i), eat_ready, 1);
            applyStimulus(eat_tab[i].x, eat_tab[i].y);
            checkOutput($sformatf("vec%0d_score", i), score, eat_tab[i].exp_score);
            checkOutput($sformatf("vec%0d_remaining", i), remaining, eat_tab[i].exp_rem);
            checkOutput($sformatf("vec%0d_bit", i), beans[eat_tab[i].idx], eat_tab[i].exp_bit);
            checkOutput($sformatf("vec%0d_ready_after", i), eat_ready, 1);
        end

        for (int i = 0; i < 8; i++) begin
            rd_col = rd_tab[i].col;
            rd_row = rd_tab[i].row;
            step();
            checkOutput($sformatf("rd%0d_bean", i), rd_bean, rd_tab[i].exp_bean);
        end

        // eat_valid held high: ready alternates and only one check per two cycles
        eat_x = 10'd88;
        eat_y = 9'd88;
        checkOutput("hold_ready0", eat_ready, 1);
        eat_valid = 1'b1;
        step();
        checkOutput("hold_ready1", eat_ready, 0);
        step();
        checkOutput("hold_ready2", eat_ready, 1);
        checkOutput("hold_score_mid", score, 5);
        step();
        checkOutput("hold_ready3", eat_ready, 0);
        eat_valid = 1'b0;
        step();
        checkOutput("hold_score", score, 5);
        checkOutput("hold_remaining", remaining, 1059);

        // restart on the same edge as an acceptance drops the request
        eat_x     = 10'd168;
        eat_y     = 9'd168;
        eat_valid = 1'b1;
        restart   = 1'b1;
        step();
        eat_valid = 1'b0;
        restart   = 1'b0;
        checkOutput("rs_init_done", init_done, 0);
        checkOutput("rs_remaining", remaining, 0);
        checkOutput("rs_ready", eat_ready, 0);
        wait_init(n);
        checkOutput("rs_cycles", n, 1200);
        checkOutput("rs_score_kept", score, 5);
        checkOutput("rs_remaining_full", remaining, 1064);
        checkOutput("rs_bean410", beans[410], 1);

        // eat every interior bean to clear the level
        for (int r = 1; r < 29; r++) begin
            for (int c = 1; c < 39; c++) begin
                applyStimulus(10'(c * 16 + 8), 9'(r * 16 + 8));
            end
        end
        checkOutput("clear_remaining", remaining, 0);
        checkOutput("clear_score", score, 1069);
        checkOutput("clear_all_eaten", all_eaten, 1);

        restart = 1'b1;
        step();
        restart = 1'b0;
        checkOutput("lvl_all_eaten", all_eaten, 0);
        wait_init(n);
        checkOutput("lvl_cycles", n, 1200);
        checkOutput("lvl_remaining", remaining, 1064);
        checkOutput("lvl_score_kept", score, 1069);

        // reset in the middle of a fill
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (500) step();
        rst = 1'b1;
        step();
        checkOutput("mid_rst_score", score, 0);
        checkOutput("mid_rst_remaining", remaining, 0);
        checkOutput("mid_rst_beans_zero", (beans == '0) ? 1 : 0, 1);
        rst = 1'b0;
        repeat (41) step();
        checkOutput("mid_rst_bean41_pending", beans[41], 0);
        step();
        checkOutput("mid_rst_bean41_written", beans[41], 1);
        wait_init(n);
        checkOutput("mid_rst_rest_cycles", n, 1158);
        checkOutput("mid_rst_remaining_full", remaining, 1064);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
